// File: rtl/fifo_ctrl_pkg.sv
// Shared helpers for the FIFO pointer/flag controller.
// FIFO_RAM_CTRL_OUTREG_EN adds one word of capacity for the registered output stage.
package fifo_ctrl_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int widthad);
    return widthad + 1;
  endfunction

  function automatic int capacity(input int numwords);
`ifdef FIFO_RAM_CTRL_OUTREG_EN
    return numwords + 1;
`else
    return numwords;
`endif
  endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// One-entry valid/ready register slice placed after the storage read port.
// Used by fifo_ram_ctrl only when FIFO_RAM_CTRL_OUTREG_EN is defined.
module fifo_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clken) begin
      if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Pointer/flag controller driving an external dual-port storage array as a streaming FIFO.
// FIFO_RAM_CTRL_OUTREG_EN: registered output stage (latency 2, capacity NUMWORDS+1).
module fifo_ram_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int WIDTHAD  = 4,
  parameter int NUMWORDS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clken,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTHAD-1:0] ram_address_a,
  output logic               ram_wren_a,
  output logic [WIDTH-1:0]   ram_data_a,
  output logic [WIDTHAD-1:0] ram_address_b,
  input  logic [WIDTH-1:0]   ram_q_b,
  output logic [WIDTHAD:0]   count,
  output logic               empty,
  output logic               full
);

  localparam int PW  = ptr_w(WIDTHAD);
  localparam int CAP = capacity(NUMWORDS);
  localparam logic [WIDTHAD:0] CAP_CNT = (WIDTHAD+1)'(CAP);

  if (NUMWORDS != (1 << WIDTHAD) || clog2(NUMWORDS) != WIDTHAD) begin : g_bad_depth
    $error("fifo_ram_ctrl: NUMWORDS must equal 2**WIDTHAD");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_fire, rd_fire, rd_adv;

  assign empty = (count == '0);
  assign full  = (count == CAP_CNT);

  // reset_n gating keeps a write from reaching storage while reset is held.
  assign wr_ready = clken & reset_n & ~full;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;

  assign ram_wren_a    = wr_fire;
  assign ram_data_a    = wr_data;
  assign ram_address_a = wr_ptr[WIDTHAD-1:0];
  assign ram_address_b = rd_ptr[WIDTHAD-1:0];

`ifdef FIFO_RAM_CTRL_OUTREG_EN
  logic             s_empty, st_in_ready, st_valid;
  logic [WIDTH-1:0] st_data;

  assign s_empty = (wr_ptr == rd_ptr);
  // Storage drains into the stage whenever the stage has room, independent of the consumer.
  assign rd_adv  = clken & ~s_empty & st_in_ready;

  fifo_out_stage #(.WIDTH(WIDTH)) u_out_stage (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .in_valid  (~s_empty),
    .in_ready  (st_in_ready),
    .in_data   (ram_q_b),
    .out_valid (st_valid),
    .out_ready (rd_ready),
    .out_data  (st_data)
  );

  assign rd_valid = clken & st_valid;
  assign rd_data  = rd_valid ? st_data : '0;
`else
  assign rd_adv   = rd_fire;
  assign rd_valid = clken & ~empty;
  assign rd_data  = rd_valid ? ram_q_b : '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clken) begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv)  rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed bench for fifo_ram_ctrl paired with a zero-latency-read storage model.
// Honours FIFO_RAM_CTRL_OUTREG_EN for capacity and latency expectations.
module tb_fifo_ram_ctrl;
  localparam int W  = 32;
  localparam int AW = 4;
  localparam int NW = 16;
`ifdef FIFO_RAM_CTRL_OUTREG_EN
  localparam int C   = 17;
  localparam int LAT = 2;
`else
  localparam int C   = 16;
  localparam int LAT = 1;
`endif

  logic          clk, reset_n, clken;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [W-1:0]  wr_data, rd_data, ram_data_a, ram_q_b;
  logic [AW-1:0] ram_address_a, ram_address_b;
  logic          ram_wren_a, empty, full;
  logic [AW:0]   count;

  fifo_ram_ctrl #(.WIDTH(W), .WIDTHAD(AW), .NUMWORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a), .ram_data_a(ram_data_a),
    .ram_address_b(ram_address_b), .ram_q_b(ram_q_b),
    .count(count), .empty(empty), .full(full)
  );

  // Storage model: synchronous write, combinational read.
  logic [W-1:0] mem [NW];
  always @(posedge clk) if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
  assign ram_q_b = mem[ram_address_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail, mcount;
  logic [31:0] q[$];

  typedef struct {
    logic        wv, rr, ce;
    logic [31:0] wd;
    logic        exp_wr_ready, exp_rd_valid, exp_wren;
    logic [31:0] exp_rd_data;
    logic [4:0]  exp_count;
  } vec_t;
  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; clken = 1'b1; wr_data = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mcount = 0;
    q.delete();
  endtask

  // One cycle with model-driven checks and scoreboard update.
  task automatic cyc(input logic wv, input logic rr, input logic ce, input logic [31:0] wd);
    logic wacc, racc;
    @(negedge clk);
    wr_valid = wv; rd_ready = rr; clken = ce; wr_data = wd;
    #1;
    check("count", count, mcount);
    check("wr_ready", wr_ready, ce && (mcount != C));
    check("empty", empty, mcount == 0);
    check("full", full, mcount == C);
    check("ram_wren_a", ram_wren_a, ce && wv && (mcount != C));
    if (!ce) check("rd_valid_stalled", rd_valid, 0);
    if (!rd_valid) check("rd_data_idle", rd_data, 0);
    wacc = ce && wv && (mcount != C);
    racc = rd_valid && rr;
    if (racc) begin
      if (q.size() == 0) check("rd_underflow", rd_valid, 0);
      else check("rd_data", rd_data, q.pop_front());
    end
    if (wacc) q.push_back(wd);
    if (wacc && !racc) mcount++;
    else if (racc && !wacc) mcount--;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    bit seen;
    n_chk = 0; n_fail = 0; mcount = 0;
    for (int i = 0; i < NW; i++) mem[i] = '0;

    // Test 1 vectors: single word through, then a stalled cycle.
    tv.push_back('{1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1, 32'h0, 5'd0});
`ifdef FIFO_RAM_CTRL_OUTREG_EN
    tv.push_back('{1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd1});
`endif
    tv.push_back('{1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 5'd1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0});
    tv.push_back('{1'b1, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0});

    reset_n = 1'b0; clken = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    do_reset();
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);

    foreach (tv[i]) begin
      @(negedge clk);
      wr_valid = tv[i].wv; rd_ready = tv[i].rr; clken = tv[i].ce; wr_data = tv[i].wd;
      #1;
      check($sformatf("t1_wr_ready[%0d]", i), wr_ready, tv[i].exp_wr_ready);
      check($sformatf("t1_rd_valid[%0d]", i), rd_valid, tv[i].exp_rd_valid);
      check($sformatf("t1_rd_data[%0d]", i), rd_data, tv[i].exp_rd_data);
      check($sformatf("t1_count[%0d]", i), count, tv[i].exp_count);
      check($sformatf("t1_wren[%0d]", i), ram_wren_a, tv[i].exp_wren);
    end

    // Test 2: fill to capacity, then an extra write is refused.
    do_reset();
    for (int i = 0; i < C; i++) cyc(1'b1, 1'b0, 1'b1, 32'h100 + i);
    cyc(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("t2_full", full, 1);
    check("t2_count", count, C);

    // Test 3: from full, concurrent read+write across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h2000 + i);
      check("t3_count_range", (count >= C - 1) && (count <= C), 1);
    end

    // Test 4: from empty, streaming at one word per cycle.
    do_reset();
    seen = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h3000 + i);
      if (seen) begin
        check("t4_throughput", rd_valid, 1);
        check("t4_not_empty", empty, 0);
      end
      if (rd_valid && !seen) begin
        seen = 1;
        first = i;
      end
    end
    check("t4_latency", first, LAT);

    // Test 5: three stalled cycles mid-stream, then resume and drain.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h4000 + i);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 32'h5000 + i);
    for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1, 1'b1, 32'h0);
    check("t5_drain_count", count, 0);
    check("t5_drain_empty", empty, 1);

    // Test 6: asynchronous reset with 9 words held.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 32'h6000 + i);
    @(negedge clk);
    check("t6_count9", count, 9);
    wr_valid = 1'b1; wr_data = 32'hBAD0_BAD0; clken = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    check("t6_wren", ram_wren_a, 0);
    check("t6_rd_valid", rd_valid, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mcount = 0;
    q.delete();
    cyc(1'b1, 1'b0, 1'b1, 32'hBEEF_0001);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 32'h0);
    check("t6_post_read_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
